// File: rtl/modadd_pkg.sv
// modadd_pkg
// Shared definitions for the modular-adder arbiter slice:
//   FIELD_WIDTH      operand/result width of the shared modadder
//   state_t          arbiter FSM state encodings
//   DEFAULT_TIMEOUT  default WAIT-state cycle limit, used only when the
//                    optional timeout (MODADD_ARB_TIMEOUT_EN) is compiled in
//   ring_add         (base + step) mod n, used for round-robin index math
package modadd_pkg;

  localparam int FIELD_WIDTH     = 381;
  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Wrapping add on a ring of n slots; base and step are assumed < n.
  function automatic int ring_add(input int base, input int step, input int n);
    return (base + step) % n;
  endfunction

endpackage

// File: rtl/modadd_arbiter_rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin selector. Scans the request vector
// starting at index ptr and wrapping modulo NUM_REQ; the first asserted
// request wins. The pointer register itself lives in the parent.
// Ports:
//   req    in   NUM_REQ  request vector
//   ptr    in   PTR_W    highest-priority index for this scan
//   grant  out  NUM_REQ  one-hot winner (all zero if no request)
//   idx    out  PTR_W    encoded winner index (0 if no request)
//   any    out  1        at least one request is asserted
module rr_arbiter
  import modadd_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   idx,
  output logic               any
);

  logic [PTR_W-1:0] cand;

  // Walk the ring from ptr; 'any' doubles as the "winner found" flag so
  // later candidates cannot override the first hit.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'(ring_add(int'(ptr), i, NUM_REQ));
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/modadd_arbiter.sv
// modadd_arbiter
// Shares a single start/done modadder between NUM_REQ requesters.
// Round-robin arbitration picks a winner in IDLE, its operands are
// registered toward the adder, a one-cycle start is issued, and the
// adder result is returned to the winner with a one-cycle response pulse.
// Throughput with a 1-cycle adder is one operation per 4 cycles.
//
// Optional feature: define MODADD_ARB_TIMEOUT_EN to add parameter TIMEOUT
// and a WAIT-state watchdog. When it expires, the owner gets a response
// with rsp_result=0 and rsp_err=1. Without the macro WAIT is unbounded and
// rsp_err is tied low.
//
// Ports:
//   clk, resetn               clock, synchronous active-low reset
//   in_m                      global modulus (stable while busy)
//   req_valid/req_a/req_b/req_sub  per-requester request, operands packed
//                             at [i*WIDTH +: WIDTH]
//   req_grant                 one-hot, combinational in IDLE: accepted now
//   rsp_valid/rsp_result/rsp_err   one-cycle response to the owner
//   busy                      FSM not in IDLE
//   add_a/add_b/add_m/add_subtract/add_start   to modadder
//   add_result/add_done       from modadder
module modadd_arbiter
  import modadd_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = FIELD_WIDTH
`ifdef MODADD_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
`endif
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [WIDTH-1:0]         in_m,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_sub,
  output logic [NUM_REQ-1:0]       req_grant,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_err,
  output logic                     busy,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic [WIDTH-1:0]         add_m,
  output logic                     add_subtract,
  output logic                     add_start,
  input  logic [WIDTH-1:0]         add_result,
  input  logic                     add_done
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner;

  logic [NUM_REQ-1:0] arb_grant;
  logic [PTR_W-1:0]   arb_idx;
  logic               arb_any;
  logic [PTR_W-1:0]   next_ptr;

  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic               sel_sub;
  logic [NUM_REQ-1:0] owner_onehot;

`ifdef MODADD_ARB_TIMEOUT_EN
  localparam int CNT_W = 16;
  logic [CNT_W-1:0] wait_cnt;
  logic             rsp_err_q;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Grants are only meaningful while IDLE; in flight the arbiter output is
  // masked so a still-asserted request from the owner is not re-accepted.
  assign req_grant = (state == ST_IDLE) ? arb_grant : '0;
  assign busy      = (state != ST_IDLE);
  assign next_ptr  = PTR_W'(ring_add(int'(arb_idx), 1, NUM_REQ));

  // Winner operand mux driven by the one-hot grant so every slice select
  // uses a constant base.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_a   = req_a[i*WIDTH +: WIDTH];
        sel_b   = req_b[i*WIDTH +: WIDTH];
        sel_sub = req_sub[i];
      end
    end
  end

  always_comb begin
    owner_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == PTR_W'(i)) owner_onehot[i] = 1'b1;
    end
  end

  // Main FSM. add_start and rsp_valid are registered on the transition into
  // ISSUE/RESP so they are high for exactly the one cycle spent there.
  // add_done is only looked at in WAIT, so stray dones elsewhere (including
  // one arriving after a reset aborted an operation) are ignored.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      rsp_valid    <= '0;
      rsp_result   <= '0;
      add_a        <= '0;
      add_b        <= '0;
      add_m        <= '0;
      add_subtract <= 1'b0;
      add_start    <= 1'b0;
`ifdef MODADD_ARB_TIMEOUT_EN
      wait_cnt     <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      add_start <= 1'b0;
      rsp_valid <= '0;
`ifdef MODADD_ARB_TIMEOUT_EN
      rsp_err_q <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            add_a        <= sel_a;
            add_b        <= sel_b;
            add_subtract <= sel_sub;
            add_m        <= in_m;
            owner        <= arb_idx;
            rr_ptr       <= next_ptr;
            add_start    <= 1'b1;
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
`ifdef MODADD_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (add_done) begin
            rsp_result <= add_result;
            rsp_valid  <= owner_onehot;
            state      <= ST_RESP;
          end
`ifdef MODADD_ARB_TIMEOUT_EN
          // wait_cnt holds the number of WAIT cycles already elapsed, so
          // this fires on the TIMEOUT-th WAIT cycle.
          else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            rsp_result <= '0;
            rsp_valid  <= owner_onehot;
            rsp_err_q  <= 1'b1;
            state      <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MODADD_ARB_TIMEOUT_EN
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_modadd_arbiter.sv
// tb_modadd_arbiter
// Directed bench for modadd_arbiter with a behavioural 1-cycle modadder.
// Table-driven single-request transactions, then hand-written sequences for
// round-robin order, masked requests, reset abort and the WAIT timeout.
module tb_modadd_arbiter;

  localparam int N = 4;
  localparam int W = 381;

  logic           clk;
  logic           resetn;
  logic [W-1:0]   in_m;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_sub;
  logic [N-1:0]   req_grant;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_result;
  logic           rsp_err;
  logic           busy;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic [W-1:0]   add_m;
  logic           add_subtract;
  logic           add_start;
  logic [W-1:0]   add_result;
  logic           add_done;

  logic stub_done;
  logic stray_done;
  int   total;
  int   bad;
  int   cyc;

  modadd_arbiter #(
    .NUM_REQ (N),
    .WIDTH   (W)
`ifdef MODADD_ARB_TIMEOUT_EN
    ,
    .TIMEOUT (8)
`endif
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .in_m         (in_m),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_sub      (req_sub),
    .req_grant    (req_grant),
    .rsp_valid    (rsp_valid),
    .rsp_result   (rsp_result),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_m        (add_m),
    .add_subtract (add_subtract),
    .add_start    (add_start),
    .add_result   (add_result),
    .add_done     (add_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference modular add/sub for operands already reduced below m.
  function automatic logic [W-1:0] modRef(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] m, input logic sub);
    logic [W:0] t;
    if (!sub) begin
      t = {1'b0, a} + {1'b0, b};
      if (t >= {1'b0, m}) t = t - {1'b0, m};
    end else if (a >= b) begin
      t = {1'b0, a} - {1'b0, b};
    end else begin
      t = {1'b0, a} + {1'b0, m} - {1'b0, b};
    end
    return t[W-1:0];
  endfunction

  // 1-cycle modadder; stub_done suppresses done, stray_done injects one.
  always @(posedge clk) begin
    add_done   <= (add_start && !stub_done) || stray_done;
    add_result <= modRef(add_a, add_b, add_m, add_subtract);
  end

  typedef struct {
    int          id;
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic [63:0] res;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Requester id carries the real operands; the others carry decoys so a
  // wrong operand mux shows up as a wrong result.
  task automatic applyStimulus(input int id, input logic [63:0] a, input logic [63:0] b,
                               input logic sub, input logic [N-1:0] valid);
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = (i == id) ? W'(a) : W'(i + 1);
      req_b[i*W +: W] = (i == id) ? W'(b) : W'(2);
      req_sub[i]      = (i == id) ? sub : ~sub;
    end
    req_valid = valid;
  endtask

  // Called at a negedge with the DUT in IDLE; checks every cycle T..T+4.
  task automatic runTransaction(input vec_t v);
    logic [N-1:0] oh;
    oh = N'(1) << v.id;
    applyStimulus(v.id, v.a, v.b, v.sub, oh);
    #1;
    checkOutput("grant", 64'(req_grant), 64'(oh));
    checkOutput("busy_idle", 64'(busy), 64'd0);
    @(negedge clk);
    req_valid = '0;
    #1;
    checkOutput("start_issue", 64'(add_start), 64'd1);
    checkOutput("grant_issue", 64'(req_grant), 64'd0);
    checkOutput("add_a", add_a[63:0], v.a);
    checkOutput("add_b", add_b[63:0], v.b);
    checkOutput("add_m", add_m[63:0], 64'd97);
    checkOutput("add_sub", 64'(add_subtract), 64'(v.sub));
    checkOutput("busy_issue", 64'(busy), 64'd1);
    @(negedge clk);
    checkOutput("start_wait", 64'(add_start), 64'd0);
    checkOutput("rsp_early", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    checkOutput("rsp_valid", 64'(rsp_valid), 64'(oh));
    checkOutput("rsp_result", rsp_result[63:0], v.res);
    checkOutput("rsp_err", 64'(rsp_err), 64'd0);
    @(negedge clk);
    checkOutput("rsp_pulse", 64'(rsp_valid), 64'd0);
    checkOutput("busy_done", 64'(busy), 64'd0);
    checkOutput("rsp_hold", rsp_result[63:0], v.res);
  endtask

  // Bounded wait for the next grant; leaves the bench at the grant negedge.
  task automatic waitGrant(output int waited);
    waited = 0;
    #1;
    while (req_grant == '0 && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int exp_ptr;
    int last_cyc;
    int waited;
    logic saw_rsp;

    vecs[0] = '{id: 0, a: 64'd50, b: 64'd60, sub: 1'b0, res: 64'd13};
    vecs[1] = '{id: 2, a: 64'd10, b: 64'd30, sub: 1'b1, res: 64'd77};
    vecs[2] = '{id: 1, a: 64'd96, b: 64'd96, sub: 1'b0, res: 64'd95};
    vecs[3] = '{id: 3, a: 64'd5,  b: 64'd5,  sub: 1'b1, res: 64'd0};
    vecs[4] = '{id: 0, a: 64'd0,  b: 64'd0,  sub: 1'b0, res: 64'd0};
    vecs[5] = '{id: 3, a: 64'd96, b: 64'd1,  sub: 1'b0, res: 64'd0};
    vecs[6] = '{id: 1, a: 64'd0,  b: 64'd1,  sub: 1'b1, res: 64'd96};

    total      = 0;
    bad        = 0;
    cyc        = 0;
    resetn     = 1'b0;
    in_m       = W'(97);
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_sub    = '0;
    stub_done  = 1'b0;
    stray_done = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_grant", 64'(req_grant), 64'd0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_rsp_err", 64'(rsp_err), 64'd0);
    checkOutput("rst_start", 64'(add_start), 64'd0);
    checkOutput("rst_add_a", 64'(|add_a), 64'd0);
    checkOutput("rst_add_m", 64'(|add_m), 64'd0);
    checkOutput("rst_result", 64'(|rsp_result), 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 7; k++) runTransaction(vecs[k]);

    // Last table winner was requester 1, so the pointer now sits at 2.
    exp_ptr  = 2;
    last_cyc = 0;
    applyStimulus(0, 64'd1, 64'd1, 1'b0, 4'hF);
    for (int op = 0; op < 16; op++) begin
      waitGrant(waited);
      checkOutput("rr_grant", 64'(req_grant), 64'(N'(1) << exp_ptr));
      if (op > 0) checkOutput("rr_spacing", 64'(cyc - last_cyc), 64'd4);
      last_cyc = cyc;
      exp_ptr  = (exp_ptr + 1) % N;
      @(negedge clk);
    end
    req_valid = '0;
    repeat (3) @(negedge clk);

    // Pointer back at 2: of {1,3}, 3 is ahead in the scan.
    req_valid = 4'b1010;
    waitGrant(waited);
    checkOutput("mask_first", 64'(req_grant), 64'b1000);
    last_cyc = cyc;
    @(negedge clk);
    waitGrant(waited);
    checkOutput("mask_second", 64'(req_grant), 64'b0010);
    checkOutput("mask_spacing", 64'(cyc - last_cyc), 64'd4);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);

    // Abort in WAIT; pointer would be 2 afterwards if reset did not clear it.
    stub_done = 1'b1;
    applyStimulus(1, 64'd3, 64'd4, 1'b0, 4'b0010);
    #1;
    checkOutput("abort_grant", 64'(req_grant), 64'b0010);
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    resetn     = 1'b1;
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    saw_rsp    = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw_rsp = saw_rsp | (|rsp_valid);
    end
    checkOutput("stray_rsp", 64'(saw_rsp), 64'd0);
    checkOutput("stray_busy", 64'(busy), 64'd0);
    stub_done = 1'b0;
    req_valid = 4'b1010;
    #1;
    checkOutput("ptr_after_rst", 64'(req_grant), 64'b0010);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);

    // Adder never answers.
    stub_done = 1'b1;
    applyStimulus(0, 64'd7, 64'd8, 1'b0, 4'b0001);
    #1;
    checkOutput("to_grant", 64'(req_grant), 64'b0001);
    @(negedge clk);
    req_valid = '0;
`ifdef MODADD_ARB_TIMEOUT_EN
    waited = 0;
    while (rsp_valid == '0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("to_latency", 64'(waited), 64'd9);
    checkOutput("to_rsp_valid", 64'(rsp_valid), 64'b0001);
    checkOutput("to_rsp_err", 64'(rsp_err), 64'd1);
    checkOutput("to_rsp_result", rsp_result[63:0], 64'd0);
    @(negedge clk);
    checkOutput("to_busy", 64'(busy), 64'd0);
    checkOutput("to_err_pulse", 64'(rsp_err), 64'd0);
`else
    saw_rsp = 1'b0;
    repeat (40) begin
      @(negedge clk);
      saw_rsp = saw_rsp | (|rsp_valid);
    end
    checkOutput("hang_rsp", 64'(saw_rsp), 64'd0);
    checkOutput("hang_busy", 64'(busy), 64'd1);
    checkOutput("hang_err", 64'(rsp_err), 64'd0);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
`endif
    stub_done = 1'b0;
    @(negedge clk);

    runTransaction(vecs[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
